irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Interrupt request controller between the event sources (timer output, external pulse lines) and the CPU's four interrupt inputs pInt1..pInt4.
- Synchronises raw requests, edge-detects them and latches them as pending.
- Applies a software-written enable mask and presents one request at a time, one-hot, to the CPU by fixed priority.
- Holds each request until the CPU acknowledges it or a timeout expires.

Parameters:
- SYNC_STAGES, 2, flops per source synchroniser (min 2).
- TIMEOUT, 16, cycles irq is held without ack before it is withdrawn (min 1).
- GAP_CYCLES, 2, cycles irq is forced low between two issues (min 1).
- MASK_RST, 8'h8F, mask register value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- src  in  4  raw event requests; src[0]=timer, src[3:1]=external; asynchronous to clk.
- wr_mask  in  1  mask write strobe, one cycle.
- mask_in  in  8  mask data; bits[3:0]=per-source enable, bit7=global enable, bits[6:4] ignored.
- ack  in  1  CPU acknowledge of the currently issued interrupt.
- irq  out  4  one-hot request to CPU; irq[i] drives pInt(i+1).
- pending  out  4  latched, not yet serviced events.
- ovf  out  4  sticky: event arrived while already pending.
- busy  out  1  high in ACTIVE and GAP.

Behaviour:
- Reset (async, active-high): sync chains, edge registers, pending, ovf, irq, busy = 0; mask = MASK_RST; state = IDLE; counters = 0.
- Synchronisation and edge detection:
  - src[i] passes through SYNC_STAGES flops.
  - A rise is detected as synced=1 while the previous synced value was 0.
  - Only rising edges count; level-held sources do not re-trigger.
- Pending:
  - A detected rise sets pending[i] on the next edge, regardless of mask.
  - Rise while pending[i]=1 sets ovf[i].
  - If a rise and the ack-clear of the same bit occur in the same cycle, set wins (the event is not lost).
- Mask write:
  - wr_mask=1 loads mask_in[7] and [3:0] on that edge.
  - The same edge clears all ovf bits.
  - pending is untouched.
- Eligible = pending & mask[3:0] & {4{mask[7]}}.
- FSM states: IDLE, ACTIVE, GAP.
  - IDLE:
    - If eligible != 0: latch sel = lowest set index (src[0] highest priority), set irq = onehot(sel), load the timeout counter to TIMEOUT, go ACTIVE.
    - Otherwise stay in IDLE with irq = 0.
  - ACTIVE:
    - irq is held stable.
    - ack=1: clear pending[sel], irq <= 0, go GAP.
    - Timeout counter reaches 0 without ack: irq <= 0, pending[sel] kept, go GAP (the request retries).
    - sel becomes ineligible (mask write): irq <= 0 on the next edge, pending kept, go GAP.
    - If ack and de-masking occur in the same cycle, ack has priority.
  - GAP:
    - irq = 0 for exactly GAP_CYCLES cycles, then IDLE.
    - ack in GAP or IDLE is ignored.
- Priority is re-evaluated only in IDLE; a higher-priority event arriving during ACTIVE does not pre-empt.
- Latency (SYNC_STAGES=2): a src rise set up before edge 0 gives pending=1 after edge 2 and irq=1 after edge 3, with the FSM in IDLE and the source enabled.
- irq is registered, glitch-free and never has more than one bit set.
- Reset asserted mid-ACTIVE drops irq immediately (asynchronously).

Test Plan:
- Basic issue: reset, mask=8'h8F. Pulse src[0] high for 3 cycles.
  - pending=4'b0001 after edge 2.
  - irq=4'b0001 after edge 3.
  - ack at edge 6 gives irq=0 and pending=0 after edge 6.
  - irq stays 0 for 2 cycles after that.
- Priority: raise src[2] and src[1] on the same cycle.
  - irq=4'b0010 first.
  - After ack and the 2-cycle gap, irq=4'b0100.
  - After the second ack, pending=0.
- Timeout retry: raise src[3] and never ack.
  - irq=4'b1000 held for 16 cycles, then 0 for 2 cycles, then 4'b1000 again.
  - pending[3] stays 1 throughout.
- Masking: write mask_in=8'h0F (global off), then raise src[1].
  - pending=4'b0010, irq stays 0.
  - Write 8'h82: irq=4'b0010 within 2 cycles.
- Overflow and set-wins:
  - Two src[0] rises 4 cycles apart before ack gives ovf[0]=1.
  - A src[0] rise timed to coincide with the ack-clear leaves pending[0]=1.
  - A mask write clears ovf to 0.
- Async reset mid-ACTIVE: assert reset between clock edges while irq=4'b0001.
  - irq, pending and busy go 0 immediately and mask=8'h8F.
  - After reset is released, irq stays 0 until a new src rise.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Bundle between the interrupt controller and its software/CPU side.
// master drives requests, mask writes and ack; slave is the controller.
interface irq_ctrl_if;
  logic [3:0] src;
  logic       wr_mask;
  logic [7:0] mask_in;
  logic       ack;
  logic [3:0] irq;
  logic [3:0] pending;
  logic [3:0] ovf;
  logic       busy;

  modport master (
    output src, wr_mask, mask_in, ack,
    input  irq, pending, ovf, busy
  );

  modport slave (
    input  src, wr_mask, mask_in, ack,
    output irq, pending, ovf, busy
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: sync + rise-detect 4 sources, latch pending, issue one-hot irq by fixed priority.
// Rise to irq takes SYNC_STAGES+2 edges; irq held until ack or TIMEOUT, then GAP_CYCLES low cycles.
module irq_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 16,
  parameter int          GAP_CYCLES  = 2,
  parameter logic [7:0]  MASK_RST    = 8'h8F
) (
  input logic       clk,
  input logic       reset,
  irq_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    sync_prev;
  logic [3:0]    rise;
  logic [3:0]    pending;
  logic [3:0]    ovf;
  logic [3:0]    clr;
  logic [3:0]    mask_en;
  logic          mask_glb;
  logic [3:0]    eligible;
  logic [1:0]    pick;
  state_t        state;
  logic [1:0]    sel;
  logic [3:0]    irq_q;
  logic          busy_q;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic          unused_mask_bits;

  assign unused_mask_bits = ^bus.mask_in[6:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      sync_prev <= '0;
    end else begin
      sync_q[0] <= bus.src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign clr      = (state == ACTIVE && bus.ack) ? (4'b0001 << sel) : 4'b0000;
  assign eligible = pending & mask_en & {4{mask_glb}};

  // A new rise on the same edge as the ack-clear re-sets the bit, so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      ovf      <= '0;
      mask_en  <= MASK_RST[3:0];
      mask_glb <= MASK_RST[7];
    end else begin
      pending <= (pending & ~clr) | rise;
      if (bus.wr_mask) begin
        mask_en  <= bus.mask_in[3:0];
        mask_glb <= bus.mask_in[7];
        ovf      <= '0;
      end else begin
        ovf <= ovf | (rise & pending);
      end
    end
  end

  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) pick = 2'(i);
    end
  end

  // The last GAP cycle also performs the IDLE decision so irq is low for exactly GAP_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= 2'd0;
      irq_q   <= '0;
      busy_q  <= 1'b0;
      tmo_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            sel     <= pick;
            irq_q   <= 4'b0001 << pick;
            tmo_cnt <= TMO_LOAD;
            busy_q  <= 1'b1;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.ack || tmo_cnt == TMO_ONE || !eligible[sel]) begin
            irq_q   <= '0;
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_ONE;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_ONE) begin
            if (|eligible) begin
              sel     <= pick;
              irq_q   <= 4'b0001 << pick;
              tmo_cnt <= TMO_LOAD;
              state   <= ACTIVE;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: begin
          irq_q  <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.irq     = irq_q;
  assign bus.pending = pending;
  assign bus.ovf     = ovf;
  assign bus.busy    = busy_q;

endmodule
